fb_port_arbiter: RTL and testbench

Single-port frame-buffer SRAM arbiter for the Virtual Paint display path. It shares one synchronous SRAM port between three requesters:
- the VGA display pixel fetch, driven by the VGA controller's request strobe, which has absolute priority;
- a full-screen clear sequencer;
- a buffered paint-write stream from the cursor/brush logic.

Writes are only issued in cycles where the display is not requesting, so painting never corrupts scan-out.

---
 rtl/fb_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_fb_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// Frame-buffer SRAM port arbiter: display reads always win, then the full-screen
// clear sequencer, then the buffered paint-write FIFO. One SRAM access per clock.
module fb_port_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int FB_WORDS   = 307200
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iDisp_Req,
  input  logic [ADDR_W-1:0] iDisp_Addr,
  output logic [DATA_W-1:0] oDisp_Data,
  output logic              oDisp_Valid,
  input  logic              iWr_Valid,
  output logic              oWr_Ready,
  input  logic [ADDR_W-1:0] iWr_Addr,
  input  logic [DATA_W-1:0] iWr_Data,
  input  logic              iClear,
  input  logic [DATA_W-1:0] iClear_Data,
  output logic              oClear_Busy,
  output logic [ADDR_W-1:0] oSRAM_Addr,
  output logic [DATA_W-1:0] oSRAM_WData,
  output logic              oSRAM_WE,
  output logic              oSRAM_RE,
  input  logic [DATA_W-1:0] iSRAM_RData
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ZERO  = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FB_WORDS - 1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [0:0]        state_r;
  logic [ADDR_W-1:0] clearCnt_r;
  logic [DATA_W-1:0] clearColor_r;

  logic [ADDR_W-1:0] fifoAddr_r [FIFO_DEPTH];
  logic [DATA_W-1:0] fifoData_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  rdPtr_r;
  logic [PTR_W-1:0]  wrPtr_r;
  logic [PTR_W:0]    fifoCount_r;

  logic              rdPend_r;

  logic inClear_s;
  logic fifoEmpty_s;
  logic fifoFull_s;
  logic push_s;
  logic grantRead_s;
  logic grantClear_s;
  logic grantFifo_s;
  logic lastWord_s;

  // Slot arbitration: a FIFO entry is only eligible once it is resident.
  always_comb begin
    inClear_s    = (state_r == ST_CLEAR);
    fifoEmpty_s  = (fifoCount_r == CNT_ZERO);
    fifoFull_s   = (fifoCount_r == CNT_FULL);
    push_s       = iWr_Valid && !fifoFull_s;
    grantRead_s  = iDisp_Req;
    grantClear_s = !iDisp_Req && inClear_s;
    grantFifo_s  = !iDisp_Req && !inClear_s && !fifoEmpty_s;
    lastWord_s   = (clearCnt_r == LAST_WORD);
  end

  assign oWr_Ready = !fifoFull_s;

  // Registered SRAM command port; address and data hold when the slot is idle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oSRAM_Addr  <= ADDR_ZERO;
      oSRAM_WData <= DATA_ZERO;
      oSRAM_WE    <= 1'b0;
      oSRAM_RE    <= 1'b0;
    end else if (grantRead_s) begin
      oSRAM_Addr  <= iDisp_Addr;
      oSRAM_WE    <= 1'b0;
      oSRAM_RE    <= 1'b1;
    end else if (grantClear_s) begin
      oSRAM_Addr  <= clearCnt_r;
      oSRAM_WData <= clearColor_r;
      oSRAM_WE    <= 1'b1;
      oSRAM_RE    <= 1'b0;
    end else if (grantFifo_s) begin
      oSRAM_Addr  <= fifoAddr_r[rdPtr_r];
      oSRAM_WData <= fifoData_r[rdPtr_r];
      oSRAM_WE    <= 1'b1;
      oSRAM_RE    <= 1'b0;
    end else begin
      oSRAM_WE    <= 1'b0;
      oSRAM_RE    <= 1'b0;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rdPtr_r     <= PTR_ZERO;
      wrPtr_r     <= PTR_ZERO;
      fifoCount_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (grantFifo_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      case ({push_s, grantFifo_s})
        2'b10:   fifoCount_r <= fifoCount_r + CNT_ONE;
        2'b01:   fifoCount_r <= fifoCount_r - CNT_ONE;
        default: fifoCount_r <= fifoCount_r;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge iCLK) begin
    if (push_s) begin
      fifoAddr_r[wrPtr_r] <= iWr_Addr;
      fifoData_r[wrPtr_r] <= iWr_Data;
    end
  end

  // Clear sequencer; a restart pulse overrides the increment of the same cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r      <= ST_IDLE;
      clearCnt_r   <= ADDR_ZERO;
      clearColor_r <= DATA_ZERO;
      oClear_Busy  <= 1'b0;
    end else begin
      oClear_Busy <= iClear || inClear_s;
      case (state_r)
        ST_IDLE: begin
          if (iClear) begin
            state_r      <= ST_CLEAR;
            clearCnt_r   <= ADDR_ZERO;
            clearColor_r <= iClear_Data;
          end
        end
        ST_CLEAR: begin
          if (iClear) begin
            clearCnt_r   <= ADDR_ZERO;
            clearColor_r <= iClear_Data;
          end else if (grantClear_s) begin
            if (lastWord_s) begin
              state_r <= ST_IDLE;
            end else begin
              clearCnt_r <= clearCnt_r + ADDR_ONE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read return: SRAM data arrives the cycle after the strobe and is re-registered.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rdPend_r    <= 1'b0;
      oDisp_Valid <= 1'b0;
      oDisp_Data  <= DATA_ZERO;
    end else begin
      rdPend_r    <= oSRAM_RE;
      oDisp_Valid <= rdPend_r;
      if (rdPend_r) begin
        oDisp_Data <= iSRAM_RData;
      end
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: a transaction-level model (queues for the
// FIFO and outstanding reads, an index for the clear) plus directed scenario checks.
module tb_fb_port_arbiter;
  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int FB_WORDS   = 16;

  logic              iCLK = 1'b0;
  logic              iRST_N;
  logic              iDisp_Req;
  logic [ADDR_W-1:0] iDisp_Addr;
  logic [DATA_W-1:0] oDisp_Data;
  logic              oDisp_Valid;
  logic              iWr_Valid;
  logic              oWr_Ready;
  logic [ADDR_W-1:0] iWr_Addr;
  logic [DATA_W-1:0] iWr_Data;
  logic              iClear;
  logic [DATA_W-1:0] iClear_Data;
  logic              oClear_Busy;
  logic [ADDR_W-1:0] oSRAM_Addr;
  logic [DATA_W-1:0] oSRAM_WData;
  logic              oSRAM_WE;
  logic              oSRAM_RE;
  logic [DATA_W-1:0] iSRAM_RData = 16'h0000;

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .FB_WORDS(FB_WORDS)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iDisp_Req(iDisp_Req), .iDisp_Addr(iDisp_Addr),
    .oDisp_Data(oDisp_Data), .oDisp_Valid(oDisp_Valid),
    .iWr_Valid(iWr_Valid), .oWr_Ready(oWr_Ready),
    .iWr_Addr(iWr_Addr), .iWr_Data(iWr_Data),
    .iClear(iClear), .iClear_Data(iClear_Data), .oClear_Busy(oClear_Busy),
    .oSRAM_Addr(oSRAM_Addr), .oSRAM_WData(oSRAM_WData),
    .oSRAM_WE(oSRAM_WE), .oSRAM_RE(oSRAM_RE), .iSRAM_RData(iSRAM_RData)
  );

  always #5 iCLK = ~iCLK;

  // SRAM: read data equals the low address bits, garbage when no read was strobed.
  always @(posedge iCLK) begin
    if (oSRAM_RE) iSRAM_RData <= oSRAM_Addr[15:0];
    else          iSRAM_RData <= 16'hDEAD;
  end

  int checks = 0;
  int failures = 0;
  int tbCyc = 0;
  bit chkEn = 1'b0;

  // model state
  int          mCyc = 0;
  bit          mClearing;
  int          mClearIdx;
  logic [15:0] mColor;
  logic [18:0] mFifoA [$];
  logic [15:0] mFifoD [$];
  int          mDueQ [$];
  logic [18:0] mDAddrQ [$];
  bit          eWE, eRE, eDValid, eBusy, eReady;
  logic [18:0] eAddr;
  logic [15:0] eWData, eDData;

  // observation logs
  logic [18:0] wrAQ [$];
  logic [15:0] wrDQ [$];
  int          wrCQ [$];
  logic [15:0] dDQ [$];
  int          dCQ [$];
  int          weCnt = 0, reCnt = 0, busyCnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mFifoA.delete(); mFifoD.delete(); mDueQ.delete(); mDAddrQ.delete();
    mClearing = 1'b0; mClearIdx = 0; mColor = 16'h0000;
    eWE = 1'b0; eRE = 1'b0; eDValid = 1'b0; eBusy = 1'b0; eReady = 1'b1;
    eAddr = 19'd0; eWData = 16'h0000; eDData = 16'h0000;
  endtask

  task automatic modelStep();
    bit rdy;
    bit wasLast;
    int dummy;
    logic [18:0] a;
    if (iRST_N) begin
      mCyc++;
      rdy = (mFifoA.size() < FIFO_DEPTH);
      wasLast = 1'b0;
      if (mDueQ.size() > 0 && mDueQ[0] == mCyc) begin
        a = mDAddrQ.pop_front();
        dummy = mDueQ.pop_front();
        eDValid = 1'b1;
        eDData = a[15:0];
      end else begin
        eDValid = 1'b0;
      end
      if (iDisp_Req) begin
        eRE = 1'b1; eWE = 1'b0; eAddr = iDisp_Addr;
        mDueQ.push_back(mCyc + 2);
        mDAddrQ.push_back(iDisp_Addr);
      end else if (mClearing) begin
        eRE = 1'b0; eWE = 1'b1; eAddr = 19'(mClearIdx); eWData = mColor;
        if (mClearIdx == FB_WORDS - 1) begin
          mClearing = 1'b0;
          wasLast = 1'b1;
        end else begin
          mClearIdx++;
        end
      end else if (mFifoA.size() > 0) begin
        eRE = 1'b0; eWE = 1'b1;
        eAddr = mFifoA.pop_front();
        eWData = mFifoD.pop_front();
      end else begin
        eRE = 1'b0; eWE = 1'b0;
      end
      if (iWr_Valid && rdy) begin
        mFifoA.push_back(iWr_Addr);
        mFifoD.push_back(iWr_Data);
      end
      if (iClear) begin
        mClearing = 1'b1; mClearIdx = 0; mColor = iClear_Data;
      end
      eBusy = mClearing || wasLast;
      eReady = (mFifoA.size() < FIFO_DEPTH);
    end
  endtask

  task automatic compareAll();
    if (oSRAM_WE) begin
      wrAQ.push_back(oSRAM_Addr); wrDQ.push_back(oSRAM_WData); wrCQ.push_back(tbCyc);
      weCnt++;
    end
    if (oSRAM_RE) reCnt++;
    if (oDisp_Valid) begin dDQ.push_back(oDisp_Data); dCQ.push_back(tbCyc); end
    if (oClear_Busy) busyCnt++;
    if (chkEn) begin
      chk("m_we", 32'(oSRAM_WE), 32'(eWE));
      chk("m_re", 32'(oSRAM_RE), 32'(eRE));
      chk("m_dvalid", 32'(oDisp_Valid), 32'(eDValid));
      chk("m_busy", 32'(oClear_Busy), 32'(eBusy));
      chk("m_ready", 32'(oWr_Ready), 32'(eReady));
      if (eWE) begin
        chk("m_waddr", 32'(oSRAM_Addr), 32'(eAddr));
        chk("m_wdata", 32'(oSRAM_WData), 32'(eWData));
      end
      if (eRE) chk("m_raddr", 32'(oSRAM_Addr), 32'(eAddr));
      if (eDValid) chk("m_ddata", 32'(oDisp_Data), 32'(eDData));
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    tbCyc++;
    modelStep();
    @(negedge iCLK);
    compareAll();
  endtask

  initial begin
    int base, dbase, refCyc, errs, n, weBase, reBase, busyBase;
    iRST_N = 1'b0; iDisp_Req = 1'b0; iDisp_Addr = 19'd0; iWr_Valid = 1'b0;
    iWr_Addr = 19'd0; iWr_Data = 16'h0000; iClear = 1'b0; iClear_Data = 16'h0000;
    modelReset();
    tick(); tick();
    chk("rst_we", 32'(oSRAM_WE), 32'd0);
    chk("rst_re", 32'(oSRAM_RE), 32'd0);
    chk("rst_addr", 32'(oSRAM_Addr), 32'd0);
    chk("rst_wdata", 32'(oSRAM_WData), 32'd0);
    chk("rst_dvalid", 32'(oDisp_Valid), 32'd0);
    chk("rst_busy", 32'(oClear_Busy), 32'd0);
    chk("rst_ready", 32'(oWr_Ready), 32'd1);
    iRST_N = 1'b1;
    chkEn = 1'b1;
    tick();

    // display pipeline
    dbase = dDQ.size(); weBase = weCnt; refCyc = tbCyc;
    for (int i = 0; i < 640; i++) begin
      iDisp_Req = 1'b1; iDisp_Addr = 19'(i); tick();
    end
    iDisp_Req = 1'b0;
    repeat (5) tick();
    n = dDQ.size() - dbase;
    chk("disp_count", 32'(n), 32'd640);
    chk("disp_first_lat", 32'((n > 0) ? dCQ[dbase] - refCyc : -1), 32'd3);
    chk("disp_span", 32'((n == 640) ? dCQ[dbase + 639] - dCQ[dbase] : -1), 32'd639);
    errs = 0;
    for (int i = 0; i < n && i < 640; i++) if (dDQ[dbase + i] !== 16'(i)) errs++;
    chk("disp_order", 32'(errs), 32'd0);
    chk("disp_no_we", 32'(weCnt - weBase), 32'd0);

    // write deferral and back-pressure
    base = wrAQ.size(); weBase = weCnt;
    iDisp_Req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iWr_Valid = 1'b1; iWr_Addr = 19'(100 + i); iWr_Data = 16'hAAAA + 16'(i);
      iDisp_Addr = 19'(1000 + i); tick();
    end
    iWr_Valid = 1'b0;
    chk("defer_ready_full", 32'(oWr_Ready), 32'd0);
    iWr_Valid = 1'b1; iWr_Addr = 19'd999; iWr_Data = 16'h0999; tick();
    iWr_Valid = 1'b0; tick(); tick();
    chk("defer_no_we", 32'(weCnt - weBase), 32'd0);
    refCyc = tbCyc; iDisp_Req = 1'b0;
    repeat (8) tick();
    n = wrAQ.size() - base;
    chk("defer_count", 32'(n), 32'd4);
    errs = 0;
    for (int i = 0; i < n && i < 4; i++)
      if (wrAQ[base + i] !== 19'(100 + i) || wrDQ[base + i] !== 16'hAAAA + 16'(i)) errs++;
    chk("defer_order", 32'(errs), 32'd0);
    chk("defer_first", 32'((n > 0) ? wrCQ[base] - refCyc : -1), 32'd1);
    chk("defer_back2back", 32'((n == 4) ? wrCQ[base + 3] - wrCQ[base] : -1), 32'd3);
    chk("defer_ready_back", 32'(oWr_Ready), 32'd1);

    // clear, with a paint write queued mid-clear
    base = wrAQ.size(); busyBase = busyCnt; refCyc = tbCyc;
    iClear = 1'b1; iClear_Data = 16'h1234; tick();
    iClear = 1'b0; iClear_Data = 16'h0000;
    chk("clr_busy_rise", 32'(oClear_Busy), 32'd1);
    repeat (5) tick();
    iWr_Valid = 1'b1; iWr_Addr = 19'd500; iWr_Data = 16'hBEEF; tick();
    iWr_Valid = 1'b0;
    repeat (20) tick();
    n = wrAQ.size() - base;
    chk("clr_count", 32'(n), 32'd17);
    errs = 0;
    for (int i = 0; i < n && i < 16; i++)
      if (wrAQ[base + i] !== 19'(i) || wrDQ[base + i] !== 16'h1234) errs++;
    chk("clr_words", 32'(errs), 32'd0);
    chk("clr_paint_after", 32'((n == 17) ? {wrAQ[base + 16][15:0], wrDQ[base + 16]} : 0),
        32'h01F4BEEF);
    chk("clr_first", 32'((n > 0) ? wrCQ[base] - refCyc : -1), 32'd2);
    chk("clr_busy_len", 32'(busyCnt - busyBase), 32'd17);

    // clear restart at counter 7
    base = wrAQ.size();
    iClear = 1'b1; iClear_Data = 16'h1111; tick();
    iClear = 1'b0;
    repeat (7) tick();
    iClear = 1'b1; iClear_Data = 16'h2222; tick();
    iClear = 1'b0;
    repeat (25) tick();
    n = wrAQ.size() - base;
    chk("rst_clr_count", 32'(n), 32'd24);
    errs = 0;
    for (int i = 0; i < n && i < 24; i++) begin
      if (wrAQ[base + i] !== 19'((i < 8) ? i : i - 8)) errs++;
      if (wrDQ[base + i] !== ((i < 8) ? 16'h1111 : 16'h2222)) errs++;
    end
    chk("restart_seq", 32'(errs), 32'd0);
    chk("restart_idle", 32'(oClear_Busy), 32'd0);

    // display interleaved with a clear
    base = wrAQ.size(); dbase = dDQ.size(); reBase = reCnt;
    iClear = 1'b1; iClear_Data = 16'h5555; tick();
    iClear = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      iDisp_Req = (i % 2 == 0); iDisp_Addr = 19'(2000 + i);
      if (i % 2 == 0) n++;
      tick();
    end
    iDisp_Req = 1'b0;
    repeat (10) tick();
    chk("ilv_reads", 32'(reCnt - reBase), 32'(n));
    chk("ilv_returns", 32'(dDQ.size() - dbase), 32'd20);
    chk("ilv_clear_writes", 32'(wrAQ.size() - base), 32'd16);
    errs = 0;
    for (int i = 0; i < wrAQ.size() - base && i < 16; i++)
      if (wrAQ[base + i] !== 19'(i) || wrDQ[base + i] !== 16'h5555) errs++;
    chk("ilv_clear_seq", 32'(errs), 32'd0);

    // asynchronous reset mid-clear with two FIFO entries queued
    base = wrAQ.size();
    iClear = 1'b1; iClear_Data = 16'h7777; tick();
    iClear = 1'b0;
    iWr_Valid = 1'b1; iWr_Addr = 19'd600; iWr_Data = 16'h6000; tick();
    iWr_Addr = 19'd601; iWr_Data = 16'h6001; tick();
    iWr_Valid = 1'b0;
    repeat (3) tick();
    chk("pre_rst_writes", 32'(wrAQ.size() - base), 32'd5);
    chk("pre_rst_ready", 32'(oWr_Ready), 32'd1);
    iRST_N = 1'b0;
    modelReset();
    #1;
    chk("arst_we", 32'(oSRAM_WE), 32'd0);
    chk("arst_re", 32'(oSRAM_RE), 32'd0);
    chk("arst_addr", 32'(oSRAM_Addr), 32'd0);
    chk("arst_wdata", 32'(oSRAM_WData), 32'd0);
    chk("arst_dvalid", 32'(oDisp_Valid), 32'd0);
    chk("arst_ddata", 32'(oDisp_Data), 32'd0);
    chk("arst_busy", 32'(oClear_Busy), 32'd0);
    chk("arst_ready", 32'(oWr_Ready), 32'd1);
    tick(); tick();
    iRST_N = 1'b1;
    weBase = weCnt;
    repeat (10) tick();
    chk("post_rst_no_we", 32'(weCnt - weBase), 32'd0);
    base = wrAQ.size();
    iWr_Valid = 1'b1; iWr_Addr = 19'd700; iWr_Data = 16'h7070; tick();
    iWr_Valid = 1'b0;
    repeat (3) tick();
    chk("post_rst_push", 32'((wrAQ.size() - base == 1) ? {wrAQ[base][15:0], wrDQ[base]} : 0),
        32'h02BC7070);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
